// File: rtl/axi_lite_master_pkg.sv
// axi_lite_master_pkg: shared FSM encodings and AXI-Lite strobe constants
package axi_lite_master_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WR_RESP,
        S_RD_ADDR,
        S_RD_DATA
    } state_t;
    localparam int STRB_W = 4;
    localparam logic [STRB_W-1:0] STRB_FULL = 4'b1111;
endpackage

// File: rtl/axi_lite_master.sv
// axi_lite_master: single-outstanding request/response port to AXI-Lite initiator
import axi_lite_master_pkg::*;
module axi_lite_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    input  logic [STRB_W-1:0]     i_req_wstrb,
    output logic                  o_rsp_valid,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    output logic [ADDR_WIDTH-1:0] o_axi_awaddr,
    output logic                  o_axi_awvalid,
    input  logic                  i_axi_awready,
    output logic [DATA_WIDTH-1:0] o_axi_wdata,
    output logic [STRB_W-1:0]     o_axi_wstrb,
    output logic                  o_axi_wvalid,
    input  logic                  i_axi_wready,
    input  logic                  i_axi_bvalid,
    output logic                  o_axi_bready,
    output logic [ADDR_WIDTH-1:0] o_axi_araddr,
    output logic                  o_axi_arvalid,
    input  logic                  i_axi_arready,
    input  logic [DATA_WIDTH-1:0] i_axi_rdata,
    input  logic                  i_axi_rvalid,
    output logic                  o_axi_rready
);
    state_t                r_state;
    logic                  r_aw_done, r_w_done;
    logic                  r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready, r_rsp_valid;
    logic [ADDR_WIDTH-1:0] r_awaddr, r_araddr;
    logic [DATA_WIDTH-1:0] r_wdata, r_rdata;
    logic [STRB_W-1:0]     r_wstrb;
    logic                  w_aw_all, w_w_all, w_rd_fin;

    assign w_aw_all = r_aw_done || (r_awvalid && i_axi_awready);
    assign w_w_all  = r_w_done || (r_wvalid && i_axi_wready);
    // rvalid together with arready completes the read straight from RD_ADDR
    assign w_rd_fin = i_axi_rvalid && (r_state == S_RD_DATA || (r_state == S_RD_ADDR && i_axi_arready));

    assign o_req_ready   = (r_state == S_IDLE) && resetn;
    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_rdata   = r_rdata;
    assign o_axi_awaddr  = r_awaddr;
    assign o_axi_awvalid = r_awvalid;
    assign o_axi_wdata   = r_wdata;
    assign o_axi_wstrb   = r_wstrb;
    assign o_axi_wvalid  = r_wvalid;
    assign o_axi_bready  = r_bready;
    assign o_axi_araddr  = r_araddr;
    assign o_axi_arvalid = r_arvalid;
    assign o_axi_rready  = r_rready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_awaddr    <= '0;
            r_araddr    <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_rdata     <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: if (i_req_valid) begin
                    r_awaddr <= i_req_addr;
                    r_araddr <= i_req_addr;
                    r_wdata  <= i_req_wdata;
                    r_wstrb  <= i_req_wstrb;
                    if (i_req_we) begin
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_bready  <= 1'b1;
                        r_state   <= S_WR;
                    end else begin
                        r_arvalid <= 1'b1;
                        r_rready  <= 1'b1;
                        r_state   <= S_RD_ADDR;
                    end
                end
                S_WR: begin
                    if (r_awvalid && i_axi_awready) r_awvalid <= 1'b0;
                    if (r_wvalid && i_axi_wready) r_wvalid <= 1'b0;
                    r_aw_done <= w_aw_all && !w_w_all;
                    r_w_done  <= w_w_all && !w_aw_all;
                    if (w_aw_all && w_w_all) r_state <= S_WR_RESP;
                end
                S_WR_RESP: if (i_axi_bvalid) begin
                    r_bready    <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_IDLE;
                end
                S_RD_ADDR: if (i_axi_arready) begin
                    r_arvalid <= 1'b0;
                    r_state   <= S_RD_DATA;
                end
                S_RD_DATA: ;
                default: r_state <= S_IDLE;
            endcase
            if (w_rd_fin) begin
                r_rdata     <= i_axi_rdata;
                r_rsp_valid <= 1'b1;
                r_rready    <= 1'b0;
                r_state     <= S_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_axi_lite_master.sv
// tb_axi_lite_master: directed bench with a configurable AXI-Lite memory slave and response scoreboard
import axi_lite_master_pkg::*;
module tb_axi_lite_master;
    logic        clk, resetn;
    logic        i_req_valid, o_req_ready, i_req_we;
    logic [31:0] i_req_addr, i_req_wdata;
    logic [3:0]  i_req_wstrb;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic [31:0] o_axi_awaddr, o_axi_wdata, o_axi_araddr, i_axi_rdata;
    logic [3:0]  o_axi_wstrb;
    logic        o_axi_awvalid, i_axi_awready, o_axi_wvalid, i_axi_wready;
    logic        i_axi_bvalid, o_axi_bready, o_axi_arvalid, i_axi_arready;
    logic        i_axi_rvalid, o_axi_rready;

    axi_lite_master dut (
        .clk(clk), .resetn(resetn),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_we(i_req_we),
        .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata), .i_req_wstrb(i_req_wstrb),
        .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata),
        .o_axi_awaddr(o_axi_awaddr), .o_axi_awvalid(o_axi_awvalid), .i_axi_awready(i_axi_awready),
        .o_axi_wdata(o_axi_wdata), .o_axi_wstrb(o_axi_wstrb), .o_axi_wvalid(o_axi_wvalid),
        .i_axi_wready(i_axi_wready), .i_axi_bvalid(i_axi_bvalid), .o_axi_bready(o_axi_bready),
        .o_axi_araddr(o_axi_araddr), .o_axi_arvalid(o_axi_arvalid), .i_axi_arready(i_axi_arready),
        .i_axi_rdata(i_axi_rdata), .i_axi_rvalid(i_axi_rvalid), .o_axi_rready(o_axi_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          rd;
        logic [31:0] data;
        int          lat;
        int          acc;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    // slave model: default delays reproduce the dmem_axi_lite handshake timing
    logic [31:0] mem [16];
    int aw_dly = 1, w_dly = 2, b_dly = 0, ar_dly = 1, r_dly = 0;
    bit r_same = 0;
    int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    bit aw_got, w_got, b_pend, r_pend;
    logic [31:0] r_q;
    bit nxt_aw, nxt_w;

    assign i_axi_awready = o_axi_awvalid && aw_cnt == aw_dly;
    assign i_axi_wready  = o_axi_wvalid && w_cnt == w_dly;
    assign i_axi_bvalid  = b_pend && b_cnt >= b_dly;
    assign i_axi_arready = o_axi_arvalid && ar_cnt == ar_dly;
    assign i_axi_rvalid  = (r_pend && r_cnt >= r_dly) || (r_same && i_axi_arready);
    assign i_axi_rdata   = r_pend ? r_q : mem[o_axi_araddr[5:2]];

    always @(posedge clk) begin
        if (!resetn) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
            aw_got <= 0; w_got <= 0; b_pend <= 0; r_pend <= 0;
        end else begin
            aw_cnt <= (o_axi_awvalid && !i_axi_awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (o_axi_wvalid && !i_axi_wready) ? w_cnt + 1 : 0;
            ar_cnt <= (o_axi_arvalid && !i_axi_arready) ? ar_cnt + 1 : 0;
            nxt_aw = aw_got || (o_axi_awvalid && i_axi_awready);
            nxt_w  = w_got || (o_axi_wvalid && i_axi_wready);
            if (nxt_aw && nxt_w) begin
                for (int i = 0; i < 4; i++)
                    if (o_axi_wstrb[i]) mem[o_axi_awaddr[5:2]][8*i +: 8] <= o_axi_wdata[8*i +: 8];
                aw_got <= 0; w_got <= 0; b_pend <= 1; b_cnt <= 0;
            end else begin
                aw_got <= nxt_aw; w_got <= nxt_w;
                if (b_pend && i_axi_bvalid && o_axi_bready) b_pend <= 0;
                else if (b_pend) b_cnt <= b_cnt + 1;
            end
            if (o_axi_arvalid && i_axi_arready && !r_same) begin
                r_pend <= 1; r_cnt <= 0; r_q <= mem[o_axi_araddr[5:2]];
            end else if (r_pend && i_axi_rvalid && o_axi_rready) r_pend <= 0;
            else if (r_pend) r_cnt <= r_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resetn && o_rsp_valid) begin
            if (sb.size() == 0) chk("rsp_unexpected", 1, 0);
            else begin
                e = sb.pop_front();
                chk("rsp_latency", 64'(cyc - e.acc + 1), 64'(e.lat));
                if (e.rd) chk("rsp_rdata", o_rsp_rdata, e.data);
            end
        end
    end

    task automatic issue(input bit we, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [31:0] exp_d, input int lat);
        chk("req_ready_idle", o_req_ready, 1);
        i_req_valid = 1; i_req_we = we; i_req_addr = a; i_req_wdata = d; i_req_wstrb = s;
        sb.push_back('{!we, exp_d, lat, cyc + 1});
        @(negedge clk);
        i_req_valid = 0;
    endtask

    task automatic wait_rsp();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0) break;
        end
        chk("rsp_drain", 64'(sb.size()), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        resetn = 0; i_req_valid = 0; i_req_we = 0; i_req_addr = 0; i_req_wdata = 0; i_req_wstrb = 0;
        repeat (3) @(negedge clk);
        resetn = 1;
        #1;
        chk("rst_req_ready", o_req_ready, 1);
        chk("rst_valids", {o_axi_awvalid, o_axi_wvalid, o_axi_arvalid, o_axi_bready, o_axi_rready, o_rsp_valid}, 0);
        chk("rst_payload", {o_axi_awaddr, o_rsp_rdata}, 0);

        issue(1, 32'h10, 32'hDEAD_BEEF, STRB_FULL, 0, 5);
        wait_rsp();
        issue(0, 32'h10, 0, 0, 32'hDEAD_BEEF, 4);
        wait_rsp();
        issue(1, 32'h10, 32'h0000_00AA, 4'b0001, 0, 5);
        wait_rsp();
        chk("rdata_hold_on_write", o_rsp_rdata, 32'hDEAD_BEEF);
        issue(0, 32'h10, 0, 0, 32'hDEAD_BEAA, 4);
        wait_rsp();

        aw_dly = 3; w_dly = 0;
        issue(1, 32'h20, 32'hCAFE_F00D, STRB_FULL, 0, 6);
        for (int c = 1; c <= 6; c++) begin
            chk("wfirst_awvalid", o_axi_awvalid, c <= 4);
            if (o_axi_awvalid) chk("wfirst_awaddr", o_axi_awaddr, 32'h20);
            chk("wfirst_wvalid", o_axi_wvalid, c == 1);
            chk("wfirst_rsp", o_rsp_valid, c == 6);
            @(negedge clk);
        end
        wait_rsp();
        aw_dly = 1; w_dly = 2;
        issue(0, 32'h20, 0, 0, 32'hCAFE_F00D, 4);
        wait_rsp();

        issue(1, 32'h30, 32'h1234_5678, STRB_FULL, 0, 5);
        wait_rsp();
        r_same = 1;
        issue(0, 32'h30, 0, 0, 32'h1234_5678, 3);
        wait_rsp();
        chk("same_cycle_idle", o_req_ready, 1);
        chk("same_cycle_rdata", o_rsp_rdata, 32'h1234_5678);
        r_same = 0;

        b_dly = 20;
        chk("stall_ready_pre", o_req_ready, 1);
        i_req_valid = 1; i_req_we = 1; i_req_addr = 32'h40; i_req_wdata = 32'h1111_2222; i_req_wstrb = STRB_FULL;
        sb.push_back('{0, 0, 25, cyc + 1});
        @(negedge clk);
        i_req_addr = 32'h44; i_req_wdata = 32'h3333_4444;
        for (int c = 1; c <= 24; c++) begin
            chk("stall_req_ready", o_req_ready, 0);
            chk("stall_bready", o_axi_bready, 1);
            @(negedge clk);
        end
        chk("stall_rsp", o_rsp_valid, 1);
        chk("stall_ready_after", o_req_ready, 1);
        b_dly = 0;
        sb.push_back('{0, 0, 5, cyc + 1});
        @(negedge clk);
        chk("b2b_awvalid", o_axi_awvalid, 1);
        chk("b2b_awaddr", o_axi_awaddr, 32'h44);
        i_req_valid = 0;
        wait_rsp();
        issue(0, 32'h44, 0, 0, 32'h3333_4444, 4);
        wait_rsp();

        r_dly = 10;
        issue(0, 32'h10, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk("rd_data_rready", o_axi_rready, 1);
        chk("rd_data_arvalid", o_axi_arvalid, 0);
        resetn = 0;
        void'(sb.pop_back());
        @(negedge clk);
        chk("midrst_valids", {o_axi_awvalid, o_axi_wvalid, o_axi_arvalid, o_axi_bready, o_axi_rready, o_rsp_valid}, 0);
        chk("midrst_payload", {o_axi_araddr, o_rsp_rdata}, 0);
        resetn = 1;
        #1;
        chk("midrst_ready", o_req_ready, 1);
        repeat (15) @(negedge clk);
        #1;
        r_dly = 0;
        issue(0, 32'h10, 0, 0, 32'hDEAD_BEAA, 4);
        wait_rsp();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_lite_master.md
Name: axi_lite_master

Overview:
- AXI-Lite initiator that converts a single-beat request/response port (CPU load/store unit side) into AXI-Lite AW/W/B and AR/R transactions.
- It is the driving end for the data-memory AXI-Lite slave (dmem_axi_lite) and for any other AXI-Lite slave in the SoC.
- Only one transaction is outstanding at a time, and there is no response-code channel, matching the slave side.

Parameters:
- ADDR_WIDTH, 32, width of request and AXI addresses.
- DATA_WIDTH, 32, width of data; strobe width is fixed at 4.

Ports:
- clk  in  1  clock; everything is on the rising edge.
- resetn  in  1  reset, synchronous and active-low.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  request accepted when high together with i_req_valid.
- i_req_we  in  1  1 = write, 0 = read.
- i_req_addr  in  ADDR_WIDTH  byte address.
- i_req_wdata  in  DATA_WIDTH  write data.
- i_req_wstrb  in  4  byte enables; ignored for reads.
- o_rsp_valid  out  1  one-cycle completion pulse.
- o_rsp_rdata  out  DATA_WIDTH  read data; valid while o_rsp_valid is high on a read.
- o_axi_awaddr  out  ADDR_WIDTH
- o_axi_awvalid  out  1
- i_axi_awready  in  1
- o_axi_wdata  out  DATA_WIDTH
- o_axi_wstrb  out  4
- o_axi_wvalid  out  1
- i_axi_wready  in  1
- i_axi_bvalid  in  1
- o_axi_bready  out  1
- o_axi_araddr  out  ADDR_WIDTH
- o_axi_arvalid  out  1
- i_axi_arready  in  1
- i_axi_rdata  in  DATA_WIDTH
- i_axi_rvalid  in  1
- o_axi_rready  out  1

Behaviour:
- Reset: a rising edge with resetn=0 forces state IDLE.
  - All AXI valid/ready outputs go to 0, o_rsp_valid goes to 0.
  - All address/data/strobe output registers and o_rsp_rdata go to 0.
  - Reset mid-transaction abandons the transaction silently and produces no response pulse.
- o_req_ready = (state==IDLE) && resetn. It is decoded from state and is therefore 1 in the first cycle after reset.
- States: IDLE, WR (AW and W outstanding), WR_RESP, RD_ADDR, RD_DATA.
- IDLE, on accept (valid && ready at the edge):
  - Capture addr, wdata and wstrb into the AXI output registers.
  - Write: set awvalid=1, wvalid=1, bready=1; next state WR.
  - Read: set arvalid=1, rready=1; next state RD_ADDR.
- WR: separate aw_done and w_done flags.
  - On the edge where awvalid && awready: clear awvalid and set aw_done.
  - On the edge where wvalid && wready: clear wvalid and set w_done.
  - Either handshake order is legal, and both may occur in the same cycle.
  - When both are done (including same-edge completion): clear the flags and go to WR_RESP.
- WR_RESP: bready stays high; it is asserted from accept onward because slaves may condition bvalid on bready.
  - On bvalid && bready: bready=0, o_rsp_valid=1 for one cycle, go to IDLE.
- RD_ADDR: araddr is held stable from accept until the R handshake, because the slave may sample araddr combinationally.
  - On arready: arvalid=0, go to RD_DATA.
- RD_DATA: rready stays high.
  - On rvalid: register i_axi_rdata into o_rsp_rdata, pulse o_rsp_valid, rready=0, go to IDLE.
- Early-response rules:
  - rvalid arriving in the same cycle as arready is accepted: finish directly from RD_ADDR.
  - bvalid arriving before both AW and W are done is a slave protocol error. It is ignored and bready is held.
- Address, data and strobe outputs are stable while the corresponding valid is high.
- Payload is passed through unmodified; no alignment check is done.
- o_rsp_rdata holds its value between reads. It is not updated on writes.
- The earliest new accept is the cycle after o_rsp_valid (back-to-back, with one IDLE cycle).
- Latency against dmem_axi_lite, counting the accept edge as cycle 0:
  - Write: awvalid/wvalid in cycle 1, awready in 2, wready in 3, bvalid in 4, o_rsp_valid in 5.
  - Read: arvalid in 1, arready in 2, rvalid in 3, o_rsp_valid in 4.
- No timeout: the block waits indefinitely for a slave response.

Decomposition:
- Shared constants header (included by master and slave):
  - FSM state encodings for master states.
  - AXI-Lite strobe width (4).
  - Full-word strobe constant 4'b1111.
- No sub-module. A single FSM plus registers is natural. The bench pairs this block with dmem_axi_lite.

Test Plan:
- Reset, then idle: o_req_ready=1 and every AXI valid=0. Assert resetn=0 during RD_DATA → IDLE on the next edge, no o_rsp_valid pulse.
- Write addr 0x0000_0010, data 0xDEAD_BEEF, strb 4'hF to dmem_axi_lite → o_rsp_valid in cycle 5. A following read of 0x10 → o_rsp_valid in cycle 4 with rdata 0xDEAD_BEEF.
- Byte-strobe write 0x0000_00AA, strb 4'b0001 to addr 0x10, then read → rdata 0xDEAD_BEAA.
- Behavioural slave returns wready 3 cycles before awready → one o_rsp_valid only after bvalid; wvalid drops right after its handshake; awaddr is stable until awready.
- Behavioural slave gives arready and rvalid in the same cycle with rdata 0x1234_5678 → o_rsp_valid next cycle with 0x1234_5678, and the FSM is in IDLE.
- Slave stalls bvalid for 20 cycles with i_req_valid held high → o_req_ready stays 0 throughout, bready stays 1, and the second request is accepted the cycle after o_rsp_valid.
